// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty sequencer.
package pwm_ctrl_pkg;

  localparam int unsigned N_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus phase counter mirroring a downstream PWM counter; emits the
// count-enable strobe, the period boundary and a registered period_end pulse.
module pwm_tick_gen #(
  parameter int unsigned N   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic pwm_en_c,
  output logic boundary_c,
  output logic period_end
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  PHASE_LAST = '1;

  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  phase_q, phase_d;
  logic          period_end_q, period_end_d;

  // Both counters hold while disabled, so a frozen period resumes in place.
  always_comb begin
    presc_d      = presc_q;
    phase_d      = phase_q;
    pwm_en_c     = enable && (presc_q == PRESC_LAST);
    boundary_c   = pwm_en_c && (phase_q == PHASE_LAST);
    period_end_d = boundary_c;
    if (enable) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
    if (pwm_en_c) begin
      phase_d = phase_q + N'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      phase_q      <= '0;
      period_end_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      period_end_q <= period_end_d;
    end
  end

  assign period_end = period_end_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty sequencer driving a PWM instance: accepts targets, ramps pwm_tau by STEP
// on period boundaries. Optional clamp to DUTY_MAX via `define PWM_DUTY_CLAMP_EN.
module pwm_duty_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned DIV      = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DUTY_MAX = (1 << N) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] tgt_duty,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  output logic         pwm_en,
  output logic [N-1:0] pwm_tau,
  output logic         period_end,
  output logic         busy,
  output logic         at_target,
  output logic         clamped
);

  localparam int unsigned NW     = N + 1;
  localparam logic [N-1:0] STEP_L = N'(STEP);
  localparam logic [N:0]   STEP_W = {1'b0, STEP_L};

  state_e        state_q, state_d;
  logic [N-1:0]  tau_q, tau_d;
  logic [N-1:0]  target_q, target_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          at_q, at_d;
  logic          clamped_q, clamped_d;
  logic          pwm_en_c, boundary_c;
  logic [N-1:0]  accept_duty_c;
  logic          over_c;
  logic signed [N:0] diff_c;
  logic [N:0]        mag_c;

  pwm_tick_gen #(
    .N   (N),
    .DIV (DIV)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_en_c   (pwm_en_c),
    .boundary_c (boundary_c),
    .period_end (period_end)
  );

`ifdef PWM_DUTY_CLAMP_EN
  localparam logic [N-1:0] DUTY_MAX_L = N'(DUTY_MAX);
  assign over_c        = (tgt_duty > DUTY_MAX_L);
  assign accept_duty_c = over_c ? DUTY_MAX_L : tgt_duty;
`else
  logic [31:0] unused_duty_max;
  assign unused_duty_max = 32'(DUTY_MAX);
  assign over_c          = 1'b0;
  assign accept_duty_c   = tgt_duty;
`endif

  // Signed distance to target; magnitude decides final partial step.
  always_comb begin
    diff_c = $signed({1'b0, target_q}) - $signed({1'b0, tau_q});
    mag_c  = diff_c[N] ? NW'(-diff_c) : NW'(diff_c);
  end

  always_comb begin
    state_d   = state_q;
    tau_d     = tau_q;
    target_d  = target_q;
    clamped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          target_d  = accept_duty_c;
          clamped_d = over_c;
          state_d   = (accept_duty_c != tau_q) ? RAMP : IDLE;
        end
      end
      RAMP: begin
        if (boundary_c) begin
          if (mag_c <= STEP_W) begin
            tau_d   = target_q;
            state_d = IDLE;
          end else if (diff_c[N]) begin
            tau_d = tau_q - STEP_L;
          end else begin
            tau_d = tau_q + STEP_L;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RAMP);
    at_d    = (tau_d == target_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tau_q     <= '0;
      target_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      at_q      <= 1'b1;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tau_q     <= tau_d;
      target_q  <= target_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      at_q      <= at_d;
      clamped_q <= clamped_d;
    end
  end

  assign pwm_en    = pwm_en_c;
  assign pwm_tau   = tau_q;
  assign tgt_ready = ready_q;
  assign busy      = busy_q;
  assign at_target = at_q;
  assign clamped   = clamped_q;

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Sequencer that owns the PWM generator's enable and duty inputs. It divides the system clock into PWM count ticks and accepts new duty targets over a valid/ready handshake. It ramps the applied duty toward the target by a fixed step, applying each change only at a PWM period boundary so every period is glitch-free. It sits between the control logic and the PWM instance, driving that instance's EN and tau directly.

Parameters:
N, 8, duty / PWM counter width; must match the PWM instance width
DIV, 4, system clocks per PWM count tick (>=1)
STEP, 1, duty increment per PWM period during a ramp (1..2^N-1)
DUTY_MAX, 2^N-1, upper duty limit; used only when PWM_DUTY_CLAMP_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
enable  in  1  run/freeze for the whole block
tgt_duty  in  N  requested duty
tgt_valid  in  1  request valid
tgt_ready  out  1  block can accept a request
pwm_en  out  1  count-enable strobe to the PWM instance
pwm_tau  out  N  applied duty to the PWM instance
period_end  out  1  one-clock pulse marking each PWM period wrap
busy  out  1  ramp in progress
at_target  out  1  pwm_tau equals the stored target
clamped  out  1  one-clock pulse when an accepted target was clamped

Behaviour:
- Reset (async, rst=1) values:
  - pwm_en=0, pwm_tau=0, period_end=0, busy=0, clamped=0.
  - tgt_ready=1, at_target=1.
  - Prescaler=0, phase=0, target=0, state=IDLE.
- Prescaler:
  - Counts 0..DIV-1 while enable=1.
  - pwm_en is high for one clock when prescaler==DIV-1. With DIV=1, pwm_en=enable.
  - With enable=0, prescaler and phase hold and pwm_en=0.
- Phase counter:
  - N bits; increments on each pwm_en; wraps from 2^N-1 to 0. It mirrors the downstream PWM counter.
  - Boundary = a pwm_en cycle with phase==2^N-1.
  - period_end is registered: high in the clock after each boundary.
- States IDLE and RAMP:
  - IDLE: tgt_ready=1, busy=0. On tgt_valid&&tgt_ready, target<=tgt_duty. Next state is RAMP if tgt_duty!=pwm_tau, otherwise IDLE.
  - A boundary in the accept cycle is not used; the ramp starts at the next boundary.
  - RAMP: tgt_ready=0, busy=1. At each boundary, diff = target-pwm_tau computed in N+1 bits, signed.
    - If |diff|<=STEP: pwm_tau<=target and state goes to IDLE.
    - Otherwise pwm_tau moves by +/-STEP toward target. There is no overflow or underflow by construction.
- pwm_tau changes only on a boundary clock, so the new duty takes effect when the downstream counter reads 0.
- at_target = (pwm_tau==target), registered.
- enable=0 mid-RAMP: the ramp freezes (no boundaries occur) and tgt_ready stays 0. The ramp resumes from the held phase when enable returns.
- tgt_valid while tgt_ready=0: the request is not consumed. The requester holds tgt_valid and tgt_duty until accepted.
- rst mid-ramp: all state returns to reset values immediately, and pwm_tau drops to 0.

Optional Feature:
PWM_DUTY_CLAMP_EN
- Defined:
  - The accepted target is min(tgt_duty, DUTY_MAX).
  - clamped pulses for one clock in the accept+1 cycle when tgt_duty>DUTY_MAX.
  - A clamped target equal to pwm_tau still pulses clamped and stays IDLE.
- Undefined:
  - DUTY_MAX is ignored, the full 0..2^N-1 range is accepted, and clamped is tied to 0.

Decomposition:
- Package pwm_ctrl_pkg: state enum (IDLE, RAMP) and the default width constant N_DEF=8.
- Sub-module pwm_tick_gen: prescaler plus phase counter, producing pwm_en and the boundary/period_end. It is reusable for other PWM channels.
- Handshake, ramp arithmetic and clamp stay in the top.

Test Plan:
Common settings: N=8, DIV=2, STEP=16, so one period = 512 clocks.
1. Reset: assert rst mid-cycle -> all outputs at reset values asynchronously; after release, with enable=1, pwm_en toggles every 2nd clock and period_end occurs every 512 clocks.
2. Ramp up: accept tgt_duty=64 from IDLE with pwm_tau=0 -> pwm_tau steps 16, 32, 48, 64 on four consecutive boundaries; busy falls and tgt_ready rises with the last step; at_target=1.
3. Ramp down: from 64, accept 10 -> pwm_tau steps 48, 32, 16, 10; the final step is partial.
4. Backpressure: during a RAMP toward 64, hold tgt_valid=1 with tgt_duty=200 -> not accepted until IDLE, then accepted in the first IDLE cycle; tgt_duty=64 (no-op) -> busy stays 0.
5. Freeze/reset: drop enable for 2000 clocks mid-ramp -> pwm_en=0 and pwm_tau constant, then resumes; assert rst mid-ramp -> pwm_tau=0, state IDLE.
6. Clamp (PWM_DUTY_CLAMP_EN, DUTY_MAX=200): accept 255 -> clamped pulses once and the ramp ends at pwm_tau=200. Without the macro -> ramp ends at 255 and clamped stays 0.
